// File: rtl/char_stream_pkg.sv
// Shared constants, FSM encoding and character-class helper for char_stream_rx.
package char_stream_pkg;

  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  // True for characters the text controller can render or act on.
  function automatic logic char_allowed(input logic [7:0] c);
    return ((c >= ASCII_PRINT_LO) && (c <= ASCII_PRINT_HI)) ||
           (c == ASCII_LF) || (c == ASCII_BS);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// DATA_W x DEPTH synchronous FIFO; a push while full only lands when a pop frees the slot.
module char_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define content.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/char_stream_rx.sv
// Synchronises and glitch-filters the ARDUINO_IO character strobe, buffers characters and presents them
// one at a time with a forced idle gap. CHAR_FILTER_EN drops non-printable bytes other than LF/BS.
module char_stream_rx
  import char_stream_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GLITCH_CYC  = 4,
  parameter int unsigned MIN_GAP     = 4
) (
  input  logic                   iVGA_CLK,
  input  logic                   iRST_n,
  input  logic [DATA_W-1:0]      iData,
  input  logic                   iTrigger,
  input  logic                   iReady,
  output logic [DATA_W-1:0]      oChar,
  output logic                   oValid,
  output logic [$clog2(DEPTH):0] oCount,
  output logic                   oOverflow
);

  localparam int unsigned CNT_W = $clog2(GLITCH_CYC + 1);
  localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);

  logic [SYNC_STAGES-1:0] trig_sync;
  logic [SYNC_STAGES-1:0] sync_fill;
  logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
  logic                   trig_s;
  logic [DATA_W-1:0]      data_s;
  logic                   armed;
  logic [CNT_W-1:0]       glitch_cnt;
  logic                   accept_c;
  logic                   push_c;
  logic                   pop_c;
  logic                   full;
  logic                   empty;
  logic [DATA_W-1:0]      head;
  state_t                 state, state_n;
  logic [GAP_W-1:0]       gap_cnt, gap_n;

  assign trig_s = trig_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // sync_fill marks when trig_s reflects a real pin sample rather than the reset value.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      trig_sync <= '0;
      sync_fill <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) data_sync[i] <= '0;
    end else begin
      trig_sync <= {trig_sync[SYNC_STAGES-2:0], iTrigger};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
      data_sync[0] <= iData;
      for (int i = 1; i < int'(SYNC_STAGES); i++) data_sync[i] <= data_sync[i-1];
    end
  end

  assign accept_c = armed && trig_s && (glitch_cnt == CNT_W'(GLITCH_CYC - 1));

  // Arm on the first genuine low so a strobe held through reset yields nothing.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      armed      <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      if (sync_fill[SYNC_STAGES-1] && !trig_s) armed <= 1'b1;
      if (!trig_s) glitch_cnt <= '0;
      else if (armed && (glitch_cnt != CNT_W'(GLITCH_CYC))) glitch_cnt <= glitch_cnt + CNT_W'(1);
    end
  end

`ifdef CHAR_FILTER_EN
  assign push_c = accept_c && char_allowed(8'(data_s));
`else
  assign push_c = accept_c;
`endif

  char_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (iVGA_CLK),
    .rst_n(iRST_n),
    .push (push_c),
    .pop  (pop_c),
    .wdata(data_s),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(oCount)
  );

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
    end
  end

  // Present the head, pop on handshake, then hold oValid low for MIN_GAP cycles.
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    pop_c   = 1'b0;
    case (state)
      S_IDLE:    if (!empty) state_n = S_PRESENT;
      S_PRESENT: if (iReady) begin
        pop_c   = 1'b1;
        state_n = S_GAP;
        gap_n   = '0;
      end
      S_GAP:     if (gap_cnt == GAP_W'(MIN_GAP - 1)) state_n = S_IDLE;
                 else gap_n = gap_cnt + GAP_W'(1);
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oValid    <= 1'b0;
      oChar     <= '0;
      oOverflow <= 1'b0;
    end else begin
      oValid <= (state_n == S_PRESENT);
      if ((state == S_IDLE) && (state_n == S_PRESENT)) oChar <= head;
      if (push_c && full && !pop_c) oOverflow <= 1'b1;
    end
  end

endmodule
